// File: rtl/spike_count_classifier_pkg.sv
// Shared readout parameters and state encoding.
// Defaults match the layer_1 output width.
package snn_pkg;

  localparam int NUM_NEURONS_D = 8;
  localparam int CNT_W_D       = 8;
  localparam int WINDOW_LEN_D  = 64;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W_D = idx_w(NUM_NEURONS_D);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SCAN,
    DONE
  } state_t;

endpackage

// File: rtl/spike_counter_sat.sv
// Per-neuron spike counter.
// Holds at all-ones instead of wrapping.
module spike_counter_sat #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;
  logic             w_sat;

  assign w_sat   = (r_count == {CNT_W{1'b1}});
  assign o_count = r_count;

  // clear wins over increment; increment only below all-ones
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !w_sat) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/spike_count_classifier.sv
// Windowed spike counting with argmax readout.
// Result leaves through a valid/ready handshake.
module spike_count_classifier
  import snn_pkg::*;
#(
  parameter int NUM_NEURONS = NUM_NEURONS_D,
  parameter int CNT_W       = CNT_W_D,
  parameter int WINDOW_LEN  = WINDOW_LEN_D,
  parameter int IDX_W       = idx_w(NUM_NEURONS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [NUM_NEURONS-1:0] spike_in,
  input  logic                   result_ready,
  output logic                   busy,
  output logic                   result_valid,
  output logic [IDX_W-1:0]       class_idx,
  output logic [CNT_W-1:0]       class_count,
  output logic                   no_spike,
  input  logic [IDX_W-1:0]       count_sel,
  output logic [CNT_W-1:0]       count_out
);

  localparam int WIN_W = $clog2(WINDOW_LEN + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_clr;
  logic             w_acc;
  logic [WIN_W-1:0] r_win;
  logic             w_win_last;
  logic [IDX_W-1:0] r_scan;
  logic             w_scan_last;
  logic [IDX_W-1:0] r_best_idx;
  logic [CNT_W-1:0] r_best_cnt;
  logic             w_take;
  logic [IDX_W-1:0] w_nxt_idx;
  logic [CNT_W-1:0] w_nxt_cnt;
  logic [IDX_W-1:0] r_class_idx;
  logic [CNT_W-1:0] r_class_cnt;
  logic             r_no_spike;
  logic [CNT_W-1:0] w_cnt [NUM_NEURONS];

  for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_cnt
    spike_counter_sat #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .i_clr   (w_clr),
      .i_inc   (w_acc & spike_in[g]),
      .o_count (w_cnt[g])
    );
  end

  assign w_win_last  = (r_win == WIN_W'(WINDOW_LEN - 1));
  assign w_scan_last = (r_scan == IDX_W'(NUM_NEURONS - 1));

  // strict greater-than keeps the lowest index on ties
  assign w_take    = (w_cnt[r_scan] > r_best_cnt);
  assign w_nxt_idx = w_take ? r_scan : r_best_idx;
  assign w_nxt_cnt = w_take ? w_cnt[r_scan] : r_best_cnt;

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next state and counter controls
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_acc       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_clr       = 1'b1;
          w_state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        w_acc = 1'b1;
        if (w_win_last) begin
          w_state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (w_scan_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (result_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // window count, argmax scan and result capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_win       <= '0;
      r_scan      <= '0;
      r_best_idx  <= '0;
      r_best_cnt  <= '0;
      r_class_idx <= '0;
      r_class_cnt <= '0;
      r_no_spike  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_win       <= '0;
            r_class_idx <= '0;
            r_class_cnt <= '0;
            r_no_spike  <= 1'b0;
          end
        end
        ACCUM: begin
          r_win <= r_win + 1'b1;
          if (w_win_last) begin
            r_scan     <= '0;
            r_best_idx <= '0;
            r_best_cnt <= '0;
          end
        end
        SCAN: begin
          r_scan     <= r_scan + 1'b1;
          r_best_idx <= w_nxt_idx;
          r_best_cnt <= w_nxt_cnt;
          if (w_scan_last) begin
            r_class_idx <= w_nxt_idx;
            r_class_cnt <= w_nxt_cnt;
            r_no_spike  <= (w_nxt_cnt == '0);
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  // debug read; out-of-range selects read zero
  always_comb begin
    count_out = '0;
    if (int'(count_sel) < NUM_NEURONS) begin
      count_out = w_cnt[count_sel];
    end
  end

  assign busy         = (r_state != IDLE);
  assign result_valid = (r_state == DONE);
  assign class_idx    = r_class_idx;
  assign class_count  = r_class_cnt;
  assign no_spike     = r_no_spike;

endmodule

// File: tb/tb_spike_count_classifier.sv
// Directed bench for spike_count_classifier.
// DUT a: default widths; DUT b: 4-bit counters.
module tb_spike_count_classifier;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] spike_in;
  logic       result_ready;
  logic [2:0] count_sel;

  logic       a_busy, a_rv, a_ns;
  logic [2:0] a_idx;
  logic [7:0] a_cnt, a_cout;
  logic       b_busy, b_rv, b_ns;
  logic [2:0] b_idx;
  logic [3:0] b_cnt, b_cout;

  int vecs;
  int fails;

  spike_count_classifier u_a (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .spike_in     (spike_in),
    .result_ready (result_ready),
    .busy         (a_busy),
    .result_valid (a_rv),
    .class_idx    (a_idx),
    .class_count  (a_cnt),
    .no_spike     (a_ns),
    .count_sel    (count_sel),
    .count_out    (a_cout)
  );

  spike_count_classifier #(
    .CNT_W (4)
  ) u_b (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .spike_in     (spike_in),
    .result_ready (result_ready),
    .busy         (b_busy),
    .result_valid (b_rv),
    .class_idx    (b_idx),
    .class_count  (b_cnt),
    .no_spike     (b_ns),
    .count_sel    (count_sel),
    .count_out    (b_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int mode, input int k);
    case (mode)
      0: return 8'b0000_0100;
      1: return (k < 10) ? 8'b0010_0010 : 8'h00;
      2: return (k < 15) ? 8'h81 : 8'h80;
      default: return 8'h00;
    endcase
  endfunction

  // start at cycle T, feed 64 samples, then expect DONE at T+73
  task automatic run_window(input int mode, input string tag);
    spike_in = 8'hFF;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, 32'(a_busy), 32'd1);
    for (int k = 0; k < 64; k++) begin
      spike_in = pat(mode, k);
      @(negedge clk);
    end
    spike_in = 8'hFF;
    repeat (7) @(negedge clk);
    chk({tag, "_rv_early"}, 32'(a_rv), 32'd0);
    @(negedge clk);
    chk({tag, "_rv"}, 32'(a_rv), 32'd1);
  endtask

  task automatic handshake(input string tag);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk({tag, "_hs_rv"}, 32'(a_rv), 32'd0);
    chk({tag, "_hs_busy"}, 32'(a_busy), 32'd0);
  endtask

  initial begin
    vecs         = 0;
    fails        = 0;
    reset_n      = 1'b0;
    start        = 1'b0;
    spike_in     = 8'h00;
    result_ready = 1'b0;
    count_sel    = 3'd2;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_rv", 32'(a_rv), 32'd0);
    chk("rst_idx", 32'(a_idx), 32'd0);
    chk("rst_cnt", 32'(a_cnt), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // reset mid-window
    start    = 1'b1;
    spike_in = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_cout", 32'(a_cout), 32'd20);
    reset_n = 1'b0;
    #1;
    chk("mid_busy", 32'(a_busy), 32'd0);
    chk("mid_cout0", 32'(a_cout), 32'd0);
    chk("mid_ns", 32'(a_ns), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_idle", 32'(a_busy), 32'd0);

    // basic
    run_window(0, "basic");
    chk("basic_idx", 32'(a_idx), 32'd2);
    chk("basic_cnt", 32'(a_cnt), 32'd64);
    chk("basic_ns", 32'(a_ns), 32'd0);
    count_sel = 3'd2;
    #1;
    chk("basic_cout2", 32'(a_cout), 32'd64);
    count_sel = 3'd3;
    #1;
    chk("basic_cout3", 32'(a_cout), 32'd0);
    handshake("basic");

    // tie between neurons 1 and 5
    run_window(1, "tie");
    chk("tie_idx", 32'(a_idx), 32'd1);
    chk("tie_cnt", 32'(a_cnt), 32'd10);
    count_sel = 3'd5;
    #1;
    chk("tie_cout5", 32'(a_cout), 32'd10);
    handshake("tie");

    // saturation on the 4-bit instance
    run_window(2, "sat");
    chk("sat_b_rv", 32'(b_rv), 32'd1);
    chk("sat_b_idx", 32'(b_idx), 32'd0);
    chk("sat_b_cnt", 32'(b_cnt), 32'd15);
    count_sel = 3'd7;
    #1;
    chk("sat_b_cout7", 32'(b_cout), 32'd15);
    chk("sat_a_idx", 32'(a_idx), 32'd7);
    chk("sat_a_cnt", 32'(a_cnt), 32'd64);
    handshake("sat");

    // silence, then hold result with ready low
    run_window(3, "sil");
    chk("sil_ns", 32'(a_ns), 32'd1);
    chk("sil_idx", 32'(a_idx), 32'd0);
    chk("sil_cnt", 32'(a_cnt), 32'd0);
    for (int c = 0; c < 20; c++) begin
      start = (c == 5);
      @(negedge clk);
    end
    start = 1'b0;
    chk("hold_rv", 32'(a_rv), 32'd1);
    chk("hold_ns", 32'(a_ns), 32'd1);
    chk("hold_cnt", 32'(a_cnt), 32'd0);
    start        = 1'b1;
    result_ready = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    result_ready = 1'b0;
    chk("hold_hs_rv", 32'(a_rv), 32'd0);
    chk("hold_hs_busy", 32'(a_busy), 32'd0);
    chk("hold_keep_ns", 32'(a_ns), 32'd1);
    @(negedge clk);
    chk("hold_idle", 32'(a_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
